// File: rtl/debounce_edge_pkg.sv
// rtl/debounce_edge_pkg.sv - shared state encodings for the debounce_edge filter FSM
package debounce_edge_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

endpackage

// File: rtl/debounce_edge_sync_2ff.sv
// rtl/debounce_edge_sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit input
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - debounced level plus one-cycle rise/fall strobes from a bouncy raw input
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int STABLE_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic d_raw,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s2;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             q_n, rise_n, fall_n;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (d_raw),
        .q     (s2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_LOW;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            q     <= q_n;
            rise  <= rise_n;
            fall  <= fall_n;
        end
    end

    // A bounce back to the settled level aborts the wait regardless of tick;
    // only qualified samples of the new level advance the counter.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        q_n     = q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            S_LOW: begin
                if (s2) begin
                    state_n = S_WAIT_HI;
                    cnt_n   = '0;
                end
            end
            S_WAIT_HI: begin
                if (!s2) begin
                    state_n = S_LOW;
                    cnt_n   = '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_n = S_HIGH;
                        cnt_n   = '0;
                        q_n     = 1'b1;
                        rise_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            S_HIGH: begin
                if (!s2) begin
                    state_n = S_WAIT_LO;
                    cnt_n   = '0;
                end
            end
            S_WAIT_LO: begin
                if (s2) begin
                    state_n = S_HIGH;
                    cnt_n   = '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_n = S_LOW;
                        cnt_n   = '0;
                        q_n     = 1'b0;
                        fall_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = S_LOW;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce_edge.sv
// tb/tb_debounce_edge.sv - scoreboard bench for debounce_edge with STABLE_CYCLES=4
module tb_debounce_edge;
    import debounce_edge_pkg::*;

    localparam int SC  = 4;
    localparam int LAT = SC + 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tick  = 1'b1;
    logic d_raw = 1'b0;
    logic q, rise, fall;

    int cyc    = 0;
    int checks = 0;
    int passes = 0;
    bit tick_gated = 1'b0;

    typedef struct {
        bit is_rise;
        int at;
    } ev_t;
    ev_t exp_q[$];

    debounce_edge #(.STABLE_CYCLES(SC)) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .d_raw (d_raw),
        .q     (q),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        tick = tick_gated ? ((cyc + 1) % 3 == 0) : 1'b1;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (rise || fall) begin
            chk("rise_fall_exclusive", int'(rise & fall), 0);
            if (exp_q.size() == 0) begin
                chk("no_edge_pending", int'(rise) + int'(fall), 0);
            end else begin
                e = exp_q.pop_front();
                chk("edge_kind_is_rise", int'(rise), int'(e.is_rise));
                chk("edge_cycle", cyc, e.at);
                chk("q_with_edge", int'(q), int'(rise));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_edge(input bit r);
        exp_q.push_back('{r, cyc + LAT});
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
        step(1);
    endtask

    initial begin
        int first;
        d_raw = 1'b1;
        step(3);
        chk("reset_q", int'(q), 0);
        chk("reset_rise", int'(rise), 0);
        chk("reset_fall", int'(fall), 0);
        chk("reset_state", int'(dut.state), int'(S_LOW));

        // release with input already high
        reset = 1'b1;
        expect_edge(1'b1);
        drain("t1_rise_seen", 20);
        chk("t1_q", int'(q), 1);

        // release of the button
        d_raw = 1'b0;
        expect_edge(1'b0);
        drain("t4_fall_seen", 20);
        chk("t4_q", int'(q), 0);

        // clean press held 20 clocks
        d_raw = 1'b1;
        expect_edge(1'b1);
        step(20);
        chk("t2_rise_seen", exp_q.size(), 0);
        chk("t2_q_held", int'(q), 1);
        d_raw = 1'b0;
        expect_edge(1'b0);
        drain("t2_fall_seen", 20);

        // bounce shorter than the stability window
        d_raw = 1'b1; step(3);
        d_raw = 1'b0; step(2);
        d_raw = 1'b1; step(2);
        d_raw = 1'b0; step(15);
        chk("t3_q", int'(q), 0);
        chk("t3_state", int'(dut.state), int'(S_LOW));

        // tick asserted every third clock
        tick_gated = 1'b1;
        step(1);
        d_raw = 1'b1;
        first = cyc + 4;
        while (first % 3 != 0) first++;
        exp_q.push_back('{1'b1, first + 3 * (SC - 1)});
        drain("t5_rise_seen", 40);
        chk("t5_q", int'(q), 1);
        tick_gated = 1'b0;
        step(1);
        d_raw = 1'b0;
        expect_edge(1'b0);
        drain("t5_fall_seen", 20);

        // reset while counting toward a rise
        d_raw = 1'b1;
        step(5);
        chk("t6_state_mid", int'(dut.state), int'(S_WAIT_HI));
        chk("t6_cnt_mid", int'(dut.cnt), 2);
        reset = 1'b0;
        #1;
        chk("t6_async_q", int'(q), 0);
        chk("t6_async_state", int'(dut.state), int'(S_LOW));
        step(3);
        chk("t6_held_q", int'(q), 0);
        reset = 1'b1;
        expect_edge(1'b1);
        drain("t6_rise_seen", 20);
        chk("t6_q", int'(q), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
